// File: rtl/fetch_byte_queue.sv
// Instruction-fetch byte queue: line reads into a circular byte buffer, decode window out.
// Define FETCHQ_PERF_EN to build the perf_lines/perf_starve/perf_flush counters.
module fetch_byte_queue #(
  parameter int LINE_BYTES   = 64,
  parameter int BEAT_BYTES   = 8,
  parameter int DEPTH_BYTES  = 128,
  parameter int WINDOW_BYTES = 15
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [63:0]                        entry,
  input  logic                               redirect,
  input  logic [63:0]                        redirect_rip,
  output logic                               req_cyc,
  output logic [63:0]                        req_addr,
  input  logic                               req_ack,
  input  logic                               resp_cyc,
  input  logic [BEAT_BYTES*8-1:0]            resp_data,
  output logic                               resp_ack,
  output logic                               win_valid,
  output logic [WINDOW_BYTES*8-1:0]          win_bytes,
  output logic [63:0]                        win_rip,
  output logic [$clog2(DEPTH_BYTES):0]       occupancy,
  input  logic [$clog2(WINDOW_BYTES+1)-1:0]  consume,
  output logic [31:0]                        perf_lines,
  output logic [31:0]                        perf_starve,
  output logic [31:0]                        perf_flush,
  output logic [1:0]                         state_dbg
);
  localparam int PTR_W  = $clog2(DEPTH_BYTES);
  localparam int OCC_W  = PTR_W + 1;
  localparam int LOFF_W = $clog2(LINE_BYTES);
  localparam int BEATS  = LINE_BYTES / BEAT_BYTES;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [LOFF_W:0] BEAT_L    = (LOFF_W+1)'(BEAT_BYTES);
  localparam logic [63:0]     LINE_MASK = ~64'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RECV = 2'd2, DRAIN = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [63:0]       req_addr_q, req_addr_d;
  logic [63:0]       fetch_addr_q, fetch_addr_d;
  logic [63:0]       win_rip_q, win_rip_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [LOFF_W-1:0] skip_left_q, skip_left_d;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              flush_q, flush_d;
  logic [7:0]        buf_q [DEPTH_BYTES];
  logic [7:0]        buf_d [DEPTH_BYTES];

  logic              beat_wr, line_done, last_beat;
  logic [LOFF_W:0]   skip_take, beat_gain;
  logic [PTR_W-1:0]  beat_base;

  assign last_beat = (beat_cnt_q == BCNT_W'(BEATS - 1));
  assign skip_take = ({1'b0, skip_left_q} > BEAT_L) ? BEAT_L : {1'b0, skip_left_q};
  assign beat_gain = beat_wr ? (BEAT_L - skip_take) : '0;
  assign beat_base = wr_ptr_q + (PTR_W'(beat_cnt_q) << $clog2(BEAT_BYTES));

  // Valid/ready: req_cyc/req_addr stay put until req_ack is sampled high; every
  // resp_cyc beat is accepted in the cycle it is presented (resp_ack mirrors it).
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    flush_d      = flush_q;
    beat_cnt_d   = beat_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    fetch_addr_d = fetch_addr_q;
    skip_left_d  = skip_left_q;
    win_rip_d    = win_rip_q;
    beat_wr      = 1'b0;
    line_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A new line may only start when all of it fits ahead of the read pointer.
        if (!redirect && occ_q <= OCC_W'(DEPTH_BYTES - LINE_BYTES)) begin
          state_d    = REQ;
          req_addr_d = fetch_addr_q;
          flush_d    = 1'b0;
        end
      end
      REQ: begin
        if (redirect) flush_d = 1'b1;
        if (req_ack) begin
          beat_cnt_d = '0;
          state_d    = (flush_q || redirect) ? DRAIN : RECV;
        end
      end
      RECV: begin
        if (resp_cyc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (redirect) begin
            state_d = last_beat ? IDLE : DRAIN;
          end else begin
            beat_wr = 1'b1;
            if (last_beat) begin
              line_done = 1'b1;
              state_d   = IDLE;
            end
          end
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (resp_cyc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
    endcase

    if (beat_wr) skip_left_d = skip_left_q - LOFF_W'(skip_take);
    if (line_done) begin
      wr_ptr_d     = wr_ptr_q + PTR_W'(LINE_BYTES);
      fetch_addr_d = fetch_addr_q + 64'(LINE_BYTES);
    end
    occ_d     = occ_q + OCC_W'(beat_gain) - OCC_W'(consume);
    rd_ptr_d  = rd_ptr_q + PTR_W'(consume);
    win_rip_d = win_rip_q + 64'(consume);

    if (redirect) begin
      occ_d        = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = PTR_W'(redirect_rip[LOFF_W-1:0]);
      skip_left_d  = redirect_rip[LOFF_W-1:0];
      fetch_addr_d = redirect_rip & LINE_MASK;
      win_rip_d    = redirect_rip;
    end
  end

  // Whole beats land line-aligned; skipped leading bytes are written but never counted.
  always_comb begin
    buf_d = buf_q;
    if (beat_wr) begin
      for (int i = 0; i < BEAT_BYTES; i++) buf_d[beat_base + PTR_W'(i)] = resp_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      flush_q      <= 1'b0;
      beat_cnt_q   <= '0;
      rd_ptr_q     <= PTR_W'(entry[LOFF_W-1:0]);
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      fetch_addr_q <= entry & LINE_MASK;
      skip_left_q  <= entry[LOFF_W-1:0];
      win_rip_q    <= entry;
      for (int i = 0; i < DEPTH_BYTES; i++) buf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      flush_q      <= flush_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
      fetch_addr_q <= fetch_addr_d;
      skip_left_q  <= skip_left_d;
      win_rip_q    <= win_rip_d;
      buf_q        <= buf_d;
    end
  end

  always_comb begin
    win_bytes = '0;
    for (int i = 0; i < WINDOW_BYTES; i++) win_bytes[8*i +: 8] = buf_q[rd_ptr_q + PTR_W'(i)];
  end

  assign req_cyc   = (state_q == REQ);
  assign req_addr  = req_addr_q;
  assign resp_ack  = resp_cyc;
  assign win_valid = (occ_q >= OCC_W'(WINDOW_BYTES));
  assign win_rip   = win_rip_q;
  assign occupancy = occ_q;
  assign state_dbg = state_q;

  consume_legal: assert property (@(posedge clk) disable iff (reset)
    (consume == '0) || (win_valid && OCC_W'(consume) <= occ_q))
    else $fatal(1, "fetch_byte_queue: consume exceeds available window");

`ifdef FETCHQ_PERF_EN
  logic [31:0] perf_lines_q, perf_lines_d;
  logic [31:0] perf_starve_q, perf_starve_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_lines_d  = perf_lines_q + (line_done ? 32'd1 : 32'd0);
    perf_starve_d = perf_starve_q + (win_valid ? 32'd0 : 32'd1);
    perf_flush_d  = perf_flush_q + (redirect ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lines_q  <= '0;
      perf_starve_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      perf_lines_q  <= perf_lines_d;
      perf_starve_q <= perf_starve_d;
      perf_flush_q  <= perf_flush_d;
    end
  end

  assign perf_lines  = perf_lines_q;
  assign perf_starve = perf_starve_q;
  assign perf_flush  = perf_flush_q;
`else
  assign perf_lines  = '0;
  assign perf_starve = '0;
  assign perf_flush  = '0;
`endif
endmodule

// File: tb/tb_fetch_byte_queue.sv
// Bench for fetch_byte_queue: a byte-stream reference model plus a randomised bus responder.
module tb_fetch_byte_queue;
  localparam int LINE  = 64;
  localparam int BEAT  = 8;
  localparam int DEPTH = 128;
  localparam int WIN   = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [63:0]   entry = 64'h1000;
  logic          redirect = 1'b0;
  logic [63:0]   redirect_rip = '0;
  logic          req_cyc;
  logic [63:0]   req_addr;
  logic          req_ack = 1'b0;
  logic          resp_cyc = 1'b0;
  logic [63:0]   resp_data = '0;
  logic          resp_ack;
  logic          win_valid;
  logic [119:0]  win_bytes;
  logic [63:0]   win_rip;
  logic [7:0]    occupancy;
  logic [3:0]    consume = '0;
  logic [31:0]   perf_lines, perf_starve, perf_flush;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  fetch_byte_queue dut (
    .clk(clk), .reset(reset), .entry(entry), .redirect(redirect), .redirect_rip(redirect_rip),
    .req_cyc(req_cyc), .req_addr(req_addr), .req_ack(req_ack), .resp_cyc(resp_cyc),
    .resp_data(resp_data), .resp_ack(resp_ack), .win_valid(win_valid), .win_bytes(win_bytes),
    .win_rip(win_rip), .occupancy(occupancy), .consume(consume), .perf_lines(perf_lines),
    .perf_starve(perf_starve), .perf_flush(perf_flush), .state_dbg(state_dbg)
  );

  int checks = 0;
  int passed = 0;

  // reference model: the unread byte stream and its start address
  logic [7:0]  exp_q[$];
  logic [63:0] req_log[$];
  logic [63:0] m_rip, m_stream_end;
  logic [31:0] m_lines, m_starve, m_flush;
  int          last_size;

  // bus responder state
  logic        req_prev, req_stale, bus_active, bus_live;
  logic [63:0] req_hold, bus_line;
  int          req_wait, bus_beat;

  // scenario knobs
  int          ack_max, gap_pct, consume_mode, redir_pct, redir_at_beat;
  logic        redir_on_req, redir_now, redir_fired;
  logic [63:0] redir_target;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] base);
    logic [63:0] d;
    for (int i = 0; i < BEAT; i++) d[8*i +: 8] = mem_byte(base + 64'(i));
    return d;
  endfunction

  function automatic logic [119:0] model_window();
    logic [119:0] w;
    w = '0;
    for (int i = 0; i < WIN; i++) w[8*i +: 8] = exp_q[i];
    return w;
  endfunction

  function automatic logic [63:0] get_req(input int n);
    if (req_log.size() > n) return req_log[n];
    return '1;
  endfunction

  task automatic set_knobs(input int am, input int gp, input int cm, input int rp);
    ack_max = am; gap_pct = gp; consume_mode = cm; redir_pct = rp;
  endtask

  task automatic do_reset(input logic [63:0] e);
    reset = 1'b1; entry = e;
    redirect = 1'b0; req_ack = 1'b0; resp_cyc = 1'b0; consume = '0;
    repeat (2) @(negedge clk);
    exp_q.delete(); req_log.delete();
    m_rip = e; m_stream_end = e; m_lines = 0; m_starve = 0; m_flush = 0; last_size = 0;
    req_prev = 1'b0; req_stale = 1'b0; req_wait = 0; req_hold = '0;
    bus_active = 1'b0; bus_live = 1'b0; bus_beat = 0; bus_line = '0;
    redir_at_beat = -1; redir_on_req = 1'b0; redir_now = 1'b0; redir_fired = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_occupancy", occupancy, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_win_bytes", win_bytes, 0);
    check("rst_win_rip", win_rip, e);
    check("rst_req_cyc", req_cyc, 0);
  endtask

  task automatic cycle();
    int c, lim, sz;
    logic do_redir, beat_now;
    logic [63:0] rrip, a;
    sz = exp_q.size();
    check("occupancy", occupancy, sz);
    check("win_valid", win_valid, sz >= WIN);
    check("win_rip", win_rip, m_rip);
    if (sz >= WIN) check("win_bytes", win_bytes, model_window());
`ifdef FETCHQ_PERF_EN
    check("perf_lines", perf_lines, m_lines);
    check("perf_starve", perf_starve, m_starve);
    check("perf_flush", perf_flush, m_flush);
`else
    check("perf_zero", {perf_lines, perf_starve, perf_flush}, 96'd0);
`endif
    do_redir = 1'b0;
    rrip = '0;
    if (req_cyc && !req_prev) begin
      req_log.push_back(req_addr);
      check("req_addr", req_addr, m_stream_end & ~64'(LINE - 1));
      check("req_room", last_size <= DEPTH - LINE, 1'b1);
      req_hold = req_addr;
      req_stale = 1'b0;
      req_wait = $urandom_range(0, ack_max);
      if (redir_on_req) begin
        do_redir = 1'b1; rrip = redir_target; req_wait = 5;
        redir_on_req = 1'b0; redir_fired = 1'b1;
      end
    end else if (req_cyc) begin
      check("req_stable", req_addr, req_hold);
    end
    if (!do_redir) begin
      if (redir_now) begin
        do_redir = 1'b1; rrip = redir_target; redir_now = 1'b0; redir_fired = 1'b1;
      end else if (redir_at_beat >= 0 && bus_active && bus_live && bus_beat == redir_at_beat) begin
        do_redir = 1'b1; rrip = redir_target; redir_at_beat = -1; redir_fired = 1'b1;
      end else if (redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
        do_redir = 1'b1; rrip = 64'($urandom_range(0, 32'h00FF_FFFF));
      end
    end
    beat_now = bus_active && ($urandom_range(0, 99) >= gap_pct);
    lim = (sz < WIN) ? sz : WIN;
    c = 0;
    if (sz >= WIN) begin
      if (consume_mode == 1) c = $urandom_range(0, lim);
      else if (consume_mode == 2) c = lim;
    end

    redirect = do_redir;
    redirect_rip = rrip;
    req_ack = req_cyc && (req_wait == 0);
    if (req_cyc && req_wait > 0) req_wait--;
    resp_cyc = beat_now;
    resp_data = beat_now ? beat_data(bus_line + 64'(bus_beat * BEAT)) : 64'(0);
    consume = 4'(c);
    #1;
    check("resp_ack", resp_ack, resp_cyc);

    // effect of this cycle at the coming clock edge
    if (sz < WIN) m_starve++;
    if (beat_now) begin
      if (bus_live && !do_redir) begin
        for (int i = 0; i < BEAT; i++) begin
          a = bus_line + 64'(bus_beat * BEAT + i);
          if (a >= m_stream_end) begin
            exp_q.push_back(mem_byte(a));
            m_stream_end = a + 64'd1;
          end
        end
        if (bus_beat == LINE / BEAT - 1) m_lines++;
      end
      bus_beat++;
      if (bus_beat == LINE / BEAT) bus_active = 1'b0;
    end
    if (!do_redir) begin
      for (int i = 0; i < c; i++) void'(exp_q.pop_front());
      m_rip = m_rip + 64'(c);
    end
    if (req_cyc && req_ack) begin
      bus_active = 1'b1; bus_beat = 0; bus_line = req_addr;
      bus_live = !req_stale && !do_redir;
    end
    if (do_redir) begin
      exp_q.delete();
      m_rip = rrip; m_stream_end = rrip;
      bus_live = 1'b0;
      if (req_cyc) req_stale = 1'b1;
      m_flush++;
    end
    last_size = sz;
    req_prev = req_cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1;
    // aligned start, then fill to capacity with no consumption
    do_reset(64'h1000);
    set_knobs(2, 20, 0, 0);
    for (int i = 0; i < 300 && occupancy < 64; i++) cycle();
    check("t1_occupancy", occupancy, 64);
    check("t1_win_valid", win_valid, 1);
    check("t1_win_rip", win_rip, 64'h1000);
    check("t1_req0", get_req(0), 64'h1000);
    for (int i = 0; i < 300 && req_log.size() < 2; i++) cycle();
    check("t1_req1", get_req(1), 64'h1040);
    for (int i = 0; i < 300 && occupancy != 128; i++) cycle();
    repeat (40) cycle();
    check("t1_full_occ", occupancy, 128);
    check("t1_full_noreq", req_cyc, 0);
    check("t1_full_nreq", req_log.size(), 2);

    // misaligned start, then full-rate consumption across the buffer wrap
    do_reset(64'h100D);
    set_knobs(1, 20, 0, 0);
    for (int i = 0; i < 300 && occupancy < 51; i++) cycle();
    check("t2_occupancy", occupancy, 51);
    check("t2_byte0", win_bytes[7:0], mem_byte(64'h100D));
    check("t2_win_rip", win_rip, 64'h100D);
    set_knobs(1, 10, 2, 0);
    repeat (400) cycle();

    // redirect in the middle of a line
    do_reset(64'h1000);
    set_knobs(1, 20, 0, 0);
    redir_at_beat = 4; redir_target = 64'h2004;
    for (int i = 0; i < 400 && !(redir_fired && occupancy >= 60); i++) cycle();
    check("t3_fired", redir_fired, 1);
    check("t3_occupancy", occupancy, 60);
    check("t3_win_rip", win_rip, 64'h2004);
    check("t3_req1", get_req(1), 64'h2000);

    // redirect while the request waits five cycles for its ack
    do_reset(64'h1000);
    set_knobs(0, 20, 0, 0);
    redir_on_req = 1'b1; redir_target = 64'h2000;
    for (int i = 0; i < 400 && req_log.size() < 2; i++) cycle();
    check("t4_req0", get_req(0), 64'h1000);
    check("t4_req1", get_req(1), 64'h2000);
    for (int i = 0; i < 300 && occupancy < 64; i++) cycle();
    check("t4_occupancy", occupancy, 64);
    check("t4_win_rip", win_rip, 64'h2000);

    // three lines and one redirect for the counters
    do_reset(64'h1000);
    set_knobs(1, 20, 0, 0);
    for (int i = 0; i < 400 && occupancy != 128; i++) cycle();
    redir_now = 1'b1; redir_target = 64'h3000;
    for (int i = 0; i < 400 && !(redir_fired && occupancy >= 64); i++) cycle();
    check("t5_win_rip", win_rip, 64'h3000);
`ifdef FETCHQ_PERF_EN
    check("t5_perf_lines", perf_lines, 3);
    check("t5_perf_flush", perf_flush, 1);
`else
    check("t5_perf_off", {perf_lines, perf_starve, perf_flush}, 96'd0);
`endif

    // random traffic with random redirects
    do_reset(64'($urandom_range(0, 32'h00FF_FFFF)));
    set_knobs(4, 30, 1, 3);
    repeat (2000) cycle();
    set_knobs(1, 5, 2, 1);
    repeat (600) cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", checks, passed);
    $fatal(1, "watchdog");
  end
endmodule
